// File: rtl/venda_ctrl.sv
// venda_ctrl: vending controller for a 4-product machine.
// Accumulates 5/10/20 coins into a balance (saldo), sells a product when the
// balance covers its price, then pays back change one coin at a time.
//
// Change handshake: chg_valid/chg_coin form a valid/ack pair. While chg_valid=1
// the offered coin is held stable until chg_ack=1 is sampled; that edge takes
// the coin. chg_ack sampled while chg_valid=0 has no effect.
//
// All outputs are registered: an input sampled at edge N is visible after N.
module venda_ctrl #(
   parameter int PRICE0   = 40,
   parameter int PRICE1   = 25,
   parameter int PRICE2   = 15,
   parameter int PRICE3   = 50,
   parameter int MAXSALDO = 60,
   parameter int TIMEOUT  = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin_valid,
   input  logic [4:0] coin,
   input  logic       sel_valid,
   input  logic [1:0] sel,
   input  logic       cancel,
   input  logic       chg_ack,
   output logic [5:0] saldo,
   output logic       vend,
   output logic [1:0] prod,
   output logic       chg_valid,
   output logic [4:0] chg_coin,
   output logic       coin_rej,
   output logic       sel_err,
   output logic       busy,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      VEND   = 2'd2,
      CHANGE = 2'd3
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] tmo_cnt, tmo_nxt;

   logic [5:0] saldo_nxt;
   logic       vend_nxt;
   logic [1:0] prod_nxt;
   logic       chg_valid_nxt;
   logic [4:0] chg_coin_nxt;
   logic       coin_rej_nxt;
   logic       sel_err_nxt;
   logic       busy_nxt;

   // Price lookup for the selected product.
   function automatic logic [5:0] price_of(input logic [1:0] s);
      logic [5:0] p;
      case (s)
         2'd0:    p = 6'(PRICE0);
         2'd1:    p = 6'(PRICE1);
         2'd2:    p = 6'(PRICE2);
         default: p = 6'(PRICE3);
      endcase
      return p;
   endfunction

   // Largest dispensable coin not exceeding the remaining balance.
   function automatic logic [4:0] greedy_coin(input logic [5:0] b);
      logic [4:0] c;
      if (b >= 6'd20)      c = 5'd20;
      else if (b >= 6'd10) c = 5'd10;
      else                 c = 5'd5;
      return c;
   endfunction

   logic       coin_legal;
   logic [6:0] coin_sum;
   logic       coin_fits;
   logic       coin_ok;
   logic [5:0] sel_price;
   logic       can_buy;
   logic       any_input;
   logic       tmo_expired;
   logic [5:0] chg_left;

   assign coin_legal  = (coin == 5'd5) || (coin == 5'd10) || (coin == 5'd20);
   // 7-bit sum so 60 + 20 cannot wrap before the overflow compare.
   assign coin_sum    = {1'b0, saldo} + {2'b00, coin};
   assign coin_fits   = coin_sum <= 7'(MAXSALDO);
   assign coin_ok     = coin_legal && coin_fits;
   assign sel_price   = price_of(sel);
   assign can_buy     = saldo >= sel_price;
   assign any_input   = coin_valid || sel_valid || cancel;
   assign tmo_expired = (tmo_cnt == 8'(TIMEOUT - 1));
   assign chg_left    = saldo - {1'b0, chg_coin};
   assign state_dbg   = state;

   // State and registered outputs; reset discards any sale or change in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tmo_cnt   <= 8'd0;
         saldo     <= 6'd0;
         vend      <= 1'b0;
         prod      <= 2'd0;
         chg_valid <= 1'b0;
         chg_coin  <= 5'd0;
         coin_rej  <= 1'b0;
         sel_err   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         tmo_cnt   <= tmo_nxt;
         saldo     <= saldo_nxt;
         vend      <= vend_nxt;
         prod      <= prod_nxt;
         chg_valid <= chg_valid_nxt;
         chg_coin  <= chg_coin_nxt;
         coin_rej  <= coin_rej_nxt;
         sel_err   <= sel_err_nxt;
         busy      <= busy_nxt;
      end
   end

   // Next state and next values of every registered output.
   always_comb begin
      state_nxt     = state;
      tmo_nxt       = tmo_cnt;
      saldo_nxt     = saldo;
      vend_nxt      = 1'b0;
      prod_nxt      = prod;
      chg_valid_nxt = 1'b0;
      chg_coin_nxt  = 5'd0;
      coin_rej_nxt  = 1'b0;
      sel_err_nxt   = 1'b0;
      busy_nxt      = 1'b0;

      case (state)
         IDLE: begin
            tmo_nxt = 8'd0;
            if (sel_valid) sel_err_nxt = 1'b1;
            if (coin_valid) begin
               if (coin_ok) begin
                  saldo_nxt = coin_sum[5:0];
                  state_nxt = COUNT;
               end else begin
                  coin_rej_nxt = 1'b1;
               end
            end
         end

         COUNT: begin
            // Any buyer activity restarts the inactivity timer.
            if (any_input) tmo_nxt = 8'd0;
            else           tmo_nxt = tmo_cnt + 8'd1;

            if (cancel) begin
               // Full refund; a coin offered alongside is handed back.
               coin_rej_nxt  = coin_valid;
               state_nxt     = CHANGE;
               chg_valid_nxt = 1'b1;
               chg_coin_nxt  = greedy_coin(saldo);
               busy_nxt      = 1'b1;
            end else if (sel_valid) begin
               coin_rej_nxt = coin_valid;
               if (can_buy) begin
                  prod_nxt  = sel;
                  saldo_nxt = saldo - sel_price;
                  state_nxt = VEND;
                  vend_nxt  = 1'b1;
                  busy_nxt  = 1'b1;
               end else begin
                  sel_err_nxt = 1'b1;
               end
            end else if (coin_valid) begin
               if (coin_ok) saldo_nxt    = coin_sum[5:0];
               else         coin_rej_nxt = 1'b1;
            end else if (tmo_expired) begin
               // Buyer walked away: refund the whole balance.
               tmo_nxt       = 8'd0;
               state_nxt     = CHANGE;
               chg_valid_nxt = 1'b1;
               chg_coin_nxt  = greedy_coin(saldo);
               busy_nxt      = 1'b1;
            end
         end

         VEND: begin
            coin_rej_nxt = coin_valid;
            tmo_nxt      = 8'd0;
            if (saldo != 6'd0) begin
               state_nxt     = CHANGE;
               chg_valid_nxt = 1'b1;
               chg_coin_nxt  = greedy_coin(saldo);
               busy_nxt      = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end

         CHANGE: begin
            coin_rej_nxt  = coin_valid;
            tmo_nxt       = 8'd0;
            chg_valid_nxt = 1'b1;
            chg_coin_nxt  = chg_coin;
            busy_nxt      = 1'b1;
            if (chg_ack && chg_valid) begin
               saldo_nxt = chg_left;
               if (chg_left == 6'd0) begin
                  state_nxt     = IDLE;
                  chg_valid_nxt = 1'b0;
                  chg_coin_nxt  = 5'd0;
                  busy_nxt      = 1'b0;
               end else begin
                  chg_coin_nxt = greedy_coin(chg_left);
               end
            end
         end

         default: begin
            state_nxt = IDLE;
            saldo_nxt = 6'd0;
            tmo_nxt   = 8'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_venda_ctrl.sv
// Bench for venda_ctrl: directed vector table, hand-written multi-cycle
// sequences, then random traffic checked against a balance/change-queue model.
module tb_venda_ctrl;

   localparam int PRICE0   = 40;
   localparam int PRICE1   = 25;
   localparam int PRICE2   = 15;
   localparam int PRICE3   = 50;
   localparam int MAXSALDO = 60;
   localparam int TIMEOUT  = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       coin_valid = 1'b0;
   logic [4:0] coin = 5'd0;
   logic       sel_valid = 1'b0;
   logic [1:0] sel = 2'd0;
   logic       cancel = 1'b0;
   logic       chg_ack = 1'b0;
   logic [5:0] saldo;
   logic       vend;
   logic [1:0] prod;
   logic       chg_valid;
   logic [4:0] chg_coin;
   logic       coin_rej;
   logic       sel_err;
   logic       busy;
   logic [1:0] state_dbg;

   int checks   = 0;
   int failures = 0;

   venda_ctrl #(
      .PRICE0(PRICE0), .PRICE1(PRICE1), .PRICE2(PRICE2), .PRICE3(PRICE3),
      .MAXSALDO(MAXSALDO), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .coin_valid(coin_valid), .coin(coin),
      .sel_valid(sel_valid), .sel(sel),
      .cancel(cancel), .chg_ack(chg_ack),
      .saldo(saldo), .vend(vend), .prod(prod),
      .chg_valid(chg_valid), .chg_coin(chg_coin),
      .coin_rej(coin_rej), .sel_err(sel_err), .busy(busy),
      .state_dbg(state_dbg)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   // ---------------- comparison helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int e_saldo, input bit e_vend,
                          input int e_prod, input bit e_cvld, input int e_ccoin,
                          input bit e_rej, input bit e_err, input bit e_busy);
      chk({tag, " saldo"},     int'(saldo),     e_saldo);
      chk({tag, " vend"},      int'(vend),      int'(e_vend));
      if (e_vend) chk({tag, " prod"}, int'(prod), e_prod);
      chk({tag, " chg_valid"}, int'(chg_valid), int'(e_cvld));
      chk({tag, " chg_coin"},  int'(chg_coin),  e_ccoin);
      chk({tag, " coin_rej"},  int'(coin_rej),  int'(e_rej));
      chk({tag, " sel_err"},   int'(sel_err),   int'(e_err));
      chk({tag, " busy"},      int'(busy),      int'(e_busy));
   endtask

   // ---------------- driver ----------------
   // Called at a negedge: drive inputs, let one posedge happen, return at negedge.
   task automatic apply(input bit cv, input int cval, input bit sv, input int sval,
                        input bit cx, input bit ack);
      coin_valid = cv;
      coin       = 5'(cval);
      sel_valid  = sv;
      sel        = 2'(sval);
      cancel     = cx;
      chg_ack    = ack;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_cycle(input bit ack);
      apply(1'b0, 0, 1'b0, 0, 1'b0, ack);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_cycle(1'b0);
      rst = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit cv; int cval; bit sv; int sval; bit cx; bit ack;
      int saldo; bit vend; int prod; bit cvld; int ccoin; bit rej; bit err; bit busy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit cv, int cval, bit sv, int sval, bit cx, bit ack,
                               int s, bit v, int p, bit cvl, int cc, bit rj, bit er, bit b);
      vec_t t;
      t.cv = cv; t.cval = cval; t.sv = sv; t.sval = sval; t.cx = cx; t.ack = ack;
      t.saldo = s; t.vend = v; t.prod = p; t.cvld = cvl; t.ccoin = cc;
      t.rej = rj; t.err = er; t.busy = b;
      return t;
   endfunction

   // ---------------- reference model ----------------
   // The machine is described by its balance, a queue of change coins still
   // owed, a pending sale pulse and a count of consecutive silent cycles.
   int m_bal;
   int m_q[$];
   bit m_vend;
   int m_prod;
   int m_idle;
   bit m_rej;
   bit m_err;

   function automatic int price(int s);
      case (s)
         0: return PRICE0;
         1: return PRICE1;
         2: return PRICE2;
         default: return PRICE3;
      endcase
   endfunction

   function automatic bit legal(int c);
      return (c == 5) || (c == 10) || (c == 20);
   endfunction

   task automatic m_refund(input int amount);
      int b;
      b = amount;
      m_q.delete();
      while (b > 0) begin
         if (b >= 20)      begin m_q.push_back(20); b -= 20; end
         else if (b >= 10) begin m_q.push_back(10); b -= 10; end
         else              begin m_q.push_back(5);  b -= 5;  end
      end
   endtask

   task automatic m_reset();
      m_bal = 0; m_q.delete(); m_vend = 0; m_prod = 0; m_idle = 0;
      m_rej = 0; m_err = 0;
   endtask

   task automatic m_step(input bit cv, input int c, input bit sv, input int s,
                         input bit cx, input bit ack);
      m_rej = 0;
      m_err = 0;
      if (m_vend) begin
         m_vend = 0;
         m_rej  = cv;
         if (m_bal > 0) m_refund(m_bal);
      end else if (m_q.size() > 0) begin
         m_rej = cv;
         if (ack) m_bal -= m_q.pop_front();
      end else if (m_bal == 0) begin
         m_idle = 0;
         if (sv) m_err = 1;
         if (cv) begin
            if (legal(c) && c <= MAXSALDO) m_bal += c;
            else m_rej = 1;
         end
      end else begin
         if (cx) begin
            m_idle = 0; m_rej = cv; m_refund(m_bal);
         end else if (sv) begin
            m_idle = 0; m_rej = cv;
            if (m_bal >= price(s)) begin
               m_bal -= price(s); m_vend = 1; m_prod = s;
            end else m_err = 1;
         end else if (cv) begin
            m_idle = 0;
            if (legal(c) && m_bal + c <= MAXSALDO) m_bal += c;
            else m_rej = 1;
         end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
               m_idle = 0; m_refund(m_bal);
            end
         end
      end
   endtask

   // ---------------- main test ----------------
   initial begin
      // Reset state
      @(negedge clk);
      do_reset();
      chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);

      // Sale with exact money: 20, 20, sel 0
      vecs.push_back(mk(1,20, 0,0, 0,0,  20,0,0, 0,0, 0,0,0));
      vecs.push_back(mk(1,20, 0,0, 0,0,  40,0,0, 0,0, 0,0,0));
      vecs.push_back(mk(0,0,  1,0, 0,0,   0,1,0, 0,0, 0,0,1));
      vecs.push_back(mk(0,0,  0,0, 0,0,   0,0,0, 0,0, 0,0,0));
      // Sale with 5 change: 5, 20, 20, sel 0
      vecs.push_back(mk(1,5,  0,0, 0,0,   5,0,0, 0,0, 0,0,0));
      vecs.push_back(mk(1,20, 0,0, 0,0,  25,0,0, 0,0, 0,0,0));
      vecs.push_back(mk(1,20, 0,0, 0,0,  45,0,0, 0,0, 0,0,0));
      vecs.push_back(mk(0,0,  1,0, 0,0,   5,1,0, 0,0, 0,0,1));
      vecs.push_back(mk(0,0,  0,0, 0,0,   5,0,0, 1,5, 0,0,1));
      vecs.push_back(mk(0,0,  0,0, 0,1,   0,0,0, 0,0, 0,0,0));
      // Overflow and illegal coins at 55, then sel 3
      vecs.push_back(mk(1,20, 0,0, 0,0,  20,0,0, 0,0, 0,0,0));
      vecs.push_back(mk(1,20, 0,0, 0,0,  40,0,0, 0,0, 0,0,0));
      vecs.push_back(mk(1,10, 0,0, 0,0,  50,0,0, 0,0, 0,0,0));
      vecs.push_back(mk(1,5,  0,0, 0,0,  55,0,0, 0,0, 0,0,0));
      vecs.push_back(mk(1,10, 0,0, 0,0,  55,0,0, 0,0, 1,0,0));
      vecs.push_back(mk(1,15, 0,0, 0,0,  55,0,0, 0,0, 1,0,0));
      vecs.push_back(mk(0,0,  1,3, 0,0,   5,1,3, 0,0, 0,0,1));
      vecs.push_back(mk(0,0,  0,0, 0,0,   5,0,0, 1,5, 0,0,1));
      vecs.push_back(mk(0,0,  0,0, 0,1,   0,0,0, 0,0, 0,0,0));
      // Selection refused: in IDLE, and short balance in COUNT
      vecs.push_back(mk(0,0,  1,2, 0,0,   0,0,0, 0,0, 0,1,0));
      vecs.push_back(mk(1,10, 0,0, 0,0,  10,0,0, 0,0, 0,0,0));
      vecs.push_back(mk(0,0,  1,1, 0,0,  10,0,0, 0,0, 0,1,0));
      vecs.push_back(mk(0,0,  1,2, 0,0,  10,0,0, 0,0, 0,1,0));
      vecs.push_back(mk(1,5,  0,0, 0,0,  15,0,0, 0,0, 0,0,0));
      vecs.push_back(mk(0,0,  1,2, 0,0,   0,1,2, 0,0, 0,0,1));
      vecs.push_back(mk(0,0,  0,0, 0,0,   0,0,0, 0,0, 0,0,0));
      // Illegal coins in IDLE
      vecs.push_back(mk(1,0,  0,0, 0,0,   0,0,0, 0,0, 1,0,0));
      vecs.push_back(mk(1,7,  0,0, 0,0,   0,0,0, 0,0, 1,0,0));

      foreach (vecs[i]) begin
         apply(vecs[i].cv, vecs[i].cval, vecs[i].sv, vecs[i].sval, vecs[i].cx, vecs[i].ack);
         chk_all($sformatf("vec%0d", i), vecs[i].saldo, vecs[i].vend, vecs[i].prod,
                 vecs[i].cvld, vecs[i].ccoin, vecs[i].rej, vecs[i].err, vecs[i].busy);
      end

      // Cancel at 35 with a stalled dispenser: 20 held, then 10, then 5
      apply(1, 20, 0, 0, 0, 0);
      apply(1, 10, 0, 0, 0, 0);
      apply(1, 5,  0, 0, 0, 0);
      chk("stall saldo35", int'(saldo), 35);
      apply(0, 0, 0, 0, 1, 0);
      chk_all("stall cancel", 35, 0, 0, 1, 20, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         idle_cycle(1'b0);
         chk_all($sformatf("stall hold%0d", k), 35, 0, 0, 1, 20, 0, 0, 1);
      end
      idle_cycle(1'b1);
      chk_all("stall ack1", 15, 0, 0, 1, 10, 0, 0, 1);
      idle_cycle(1'b1);
      chk_all("stall ack2", 5, 0, 0, 1, 5, 0, 0, 1);
      idle_cycle(1'b1);
      chk_all("stall ack3", 0, 0, 0, 0, 0, 0, 0, 0);

      // Inactivity refund after 20 silent cycles; short selection first
      apply(1, 10, 0, 0, 0, 0);
      apply(0, 0, 1, 1, 0, 0);
      chk_all("tmo selerr", 10, 0, 0, 0, 0, 0, 1, 0);
      for (int k = 0; k < TIMEOUT - 1; k++) idle_cycle(1'b0);
      chk_all("tmo before", 10, 0, 0, 0, 0, 0, 0, 0);
      idle_cycle(1'b0);
      chk_all("tmo refund", 10, 0, 0, 1, 10, 0, 0, 1);
      idle_cycle(1'b1);
      chk_all("tmo done", 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset while paying out 30
      apply(1, 20, 0, 0, 0, 0);
      apply(1, 10, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 1, 0);
      chk_all("rstchg pre", 30, 0, 0, 1, 20, 0, 0, 1);
      do_reset();
      chk_all("rstchg post", 0, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 0, 1, 0, 0, 1);
      chk_all("rstchg idle", 0, 0, 0, 0, 0, 0, 1, 0);

      // cancel + sel + coin together in COUNT: refund wins, coin returned
      apply(1, 5, 0, 0, 0, 0);
      apply(1, 10, 1, 2, 1, 0);
      chk_all("prio", 5, 0, 0, 1, 5, 1, 0, 1);
      idle_cycle(1'b1);
      chk_all("prio done", 0, 0, 0, 0, 0, 0, 0, 0);

      // Random traffic against the model
      do_reset();
      m_reset();
      begin
         int quiet;
         quiet = 0;
         for (int i = 0; i < 4000; i++) begin
            bit cv, sv, cx, ack;
            int c, s, r;
            cv = 0; sv = 0; cx = 0; c = 0; s = 0;
            ack = 1'($urandom_range(0, 1));
            r = (quiet > 0) ? 100 : int'($urandom_range(0, 99));
            if (quiet > 0) quiet--;
            if (r < 2) begin
               do_reset();
               m_reset();
               chk_all("rand rst", 0, 0, 0, 0, 0, 0, 0, 0);
               continue;
            end else if (r < 4) begin
               quiet = int'($urandom_range(15, 25));
            end else if (r < 44) begin
               cv = 1;
               case ($urandom_range(0, 3))
                  0: c = 5;
                  1: c = 10;
                  2: c = 20;
                  default: c = int'($urandom_range(0, 31));
               endcase
            end else if (r < 58) begin
               sv = 1; s = int'($urandom_range(0, 3));
            end else if (r < 63) begin
               cx = 1;
            end
            m_step(cv, c, sv, s, cx, ack);
            apply(cv, c, sv, s, cx, ack);
            chk_all($sformatf("rand%0d", i), m_bal, m_vend, m_prod, m_q.size() > 0,
                    (m_q.size() > 0) ? m_q[0] : 0, m_rej, m_err,
                    m_vend || (m_q.size() > 0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
